// File: rtl/puf_pkg.sv
// Shared types and sizing helpers for the arbiter-PUF evaluation sequencer.
package puf_pkg;

  localparam int PUF_C_LENGTH = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_FIRE,
    ST_CAPTURE,
    ST_DONE
  } puf_state_t;

  // Ceiling log2 that never returns less than 1, so counters always have a bit.
  function automatic int puf_clog2(input int value);
    int w;
    w = 1;
    while ((1 << w) < value) begin
      w = w + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/puf_majority_acc.sv
// Per-bit ones counters over the evaluation runs; presents the majority vote and a unanimity flag.
module puf_majority_acc
  import puf_pkg::*;
#(
  parameter int R_WIDTH  = 7,
  parameter int NUM_EVAL = 5
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_clr,
  input  logic               i_smp,
  input  logic [R_WIDTH-1:0] i_bits,
  output logic [R_WIDTH-1:0] o_vote,
  output logic               o_stable
);

  localparam int            CW   = puf_clog2(NUM_EVAL + 1);
  localparam logic [CW-1:0] HALF = CW'(NUM_EVAL / 2);
  localparam logic [CW-1:0] ALL  = CW'(NUM_EVAL);

  logic [CW-1:0]      r_ones [R_WIDTH];
  logic [R_WIDTH-1:0] w_unan;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int b = 0; b < R_WIDTH; b++) r_ones[b] <= '0;
    end else if (i_clr) begin
      for (int b = 0; b < R_WIDTH; b++) r_ones[b] <= '0;
    end else if (i_smp) begin
      for (int b = 0; b < R_WIDTH; b++) r_ones[b] <= r_ones[b] + CW'(i_bits[b]);
    end
  end

  always_comb begin
    o_vote = '0;
    w_unan = '0;
    for (int b = 0; b < R_WIDTH; b++) begin
      o_vote[b] = (r_ones[b] > HALF);
      w_unan[b] = (r_ones[b] == '0) || (r_ones[b] == ALL);
    end
  end

  assign o_stable = &w_unan;

endmodule

// File: rtl/puf_eval_ctrl.sv
// Arbiter-PUF sequencer: settle/fire/capture NUM_EVAL times, then hold a voted response until taken.
// Response appears NUM_EVAL*(SETTLE_CYC+1+CAPTURE_CYC)+1 cycles after accept; no new command until it is taken.
module puf_eval_ctrl
  import puf_pkg::*;
#(
  parameter int C_LENGTH    = PUF_C_LENGTH,
  parameter int R_WIDTH     = 7,
  parameter int NUM_EVAL    = 5,
  parameter int SETTLE_CYC  = 4,
  parameter int CAPTURE_CYC = 2
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_cmd_valid,
  output logic                o_cmd_ready,
  input  logic [C_LENGTH-1:0] i_cmd_challenge,
  output logic [C_LENGTH-1:0] o_puf_challenge,
  output logic                o_puf_pulse,
  input  logic [R_WIDTH-1:0]  i_puf_response,
  output logic                o_rsp_valid,
  input  logic                i_rsp_ready,
  output logic [R_WIDTH-1:0]  o_rsp_data,
  output logic                o_rsp_stable,
  output logic                o_busy
);

  localparam int TW = puf_clog2(SETTLE_CYC + CAPTURE_CYC + 1);
  localparam int EW = puf_clog2(NUM_EVAL + 1);

  if ((NUM_EVAL % 2) == 0) begin : g_even_eval
    $error("puf_eval_ctrl: NUM_EVAL must be odd");
  end
  if (SETTLE_CYC < 1) begin : g_bad_settle
    $error("puf_eval_ctrl: SETTLE_CYC must be at least 1");
  end
  if (CAPTURE_CYC < 2) begin : g_bad_capture
    $error("puf_eval_ctrl: CAPTURE_CYC must be at least 2");
  end

  puf_state_t          r_state;
  logic [TW-1:0]       r_tmr;
  logic [EW-1:0]       r_eval;
  logic [C_LENGTH-1:0] r_chal;
  logic                r_pulse;
  logic                r_cmd_ready;
  logic                r_busy;
  logic                r_rsp_valid;
  logic [R_WIDTH-1:0]  r_rsp_data;
  logic                r_rsp_stable;

  logic               w_accept;
  logic               w_cap_last;
  logic [R_WIDTH-1:0] w_vote;
  logic               w_stable;

  // r_cmd_ready is only ever high in IDLE, so it doubles as the state qualifier.
  assign w_accept   = r_cmd_ready & i_cmd_valid;
  assign w_cap_last = (r_state == ST_CAPTURE) && (r_tmr == TW'(CAPTURE_CYC - 1));

  // The response is treated as quasi-static: it has settled long before the sampling edge.
  puf_majority_acc #(
    .R_WIDTH  (R_WIDTH),
    .NUM_EVAL (NUM_EVAL)
  ) u_acc (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_clr    (w_accept),
    .i_smp    (w_cap_last),
    .i_bits   (i_puf_response),
    .o_vote   (w_vote),
    .o_stable (w_stable)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state      <= ST_IDLE;
      r_tmr        <= '0;
      r_eval       <= '0;
      r_chal       <= '0;
      r_pulse      <= 1'b0;
      r_cmd_ready  <= 1'b0;
      r_busy       <= 1'b0;
      r_rsp_valid  <= 1'b0;
      r_rsp_data   <= '0;
      r_rsp_stable <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_state     <= ST_SETTLE;
            r_tmr       <= '0;
            r_eval      <= '0;
            r_chal      <= i_cmd_challenge;
            r_cmd_ready <= 1'b0;
            r_busy      <= 1'b1;
          end else begin
            r_cmd_ready <= 1'b1;
          end
        end
        ST_SETTLE: begin
          if (r_tmr == TW'(SETTLE_CYC - 1)) begin
            r_state <= ST_FIRE;
            r_tmr   <= '0;
            r_pulse <= 1'b1;
          end else begin
            r_tmr <= r_tmr + TW'(1);
          end
        end
        ST_FIRE: begin
          r_state <= ST_CAPTURE;
        end
        ST_CAPTURE: begin
          if (w_cap_last) begin
            r_tmr   <= '0;
            r_pulse <= 1'b0;
            if (r_eval == EW'(NUM_EVAL - 1)) begin
              r_state <= ST_DONE;
            end else begin
              r_state <= ST_SETTLE;
              r_eval  <= r_eval + EW'(1);
            end
          end else begin
            r_tmr <= r_tmr + TW'(1);
          end
        end
        ST_DONE: begin
          // First DONE cycle lets the final sample land in the counters before voting.
          if (!r_rsp_valid) begin
            r_rsp_valid  <= 1'b1;
            r_rsp_data   <= w_vote;
            r_rsp_stable <= w_stable;
          end else if (i_rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_state     <= ST_IDLE;
            r_busy      <= 1'b0;
            r_cmd_ready <= 1'b1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_pulse <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign o_cmd_ready     = r_cmd_ready;
  assign o_puf_challenge = r_chal;
  assign o_puf_pulse     = r_pulse;
  assign o_rsp_valid     = r_rsp_valid;
  assign o_rsp_data      = r_rsp_data;
  assign o_rsp_stable    = r_rsp_stable;
  assign o_busy          = r_busy;

endmodule

// File: tb/tb_puf_eval_ctrl.sv
// Bench for puf_eval_ctrl: elapsed-time model of the transaction plus a behavioural PUF (response = ~challenge ^ noise[run]).
module tb_puf_eval_ctrl;

  localparam int NE  = 5;
  localparam int SET = 4;
  localparam int PER = 7;
  localparam int LAT = NE * PER + 1;

  logic       i_clk = 1'b0;
  logic       i_rst = 1'b0;
  logic       i_cmd_valid = 1'b0;
  logic [7:0] i_cmd_challenge = 8'h00;
  logic [6:0] i_puf_response = 7'h00;
  logic       i_rsp_ready = 1'b1;
  logic       o_cmd_ready, o_puf_pulse, o_rsp_valid, o_rsp_stable, o_busy;
  logic [7:0] o_puf_challenge;
  logic [6:0] o_rsp_data;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  logic [6:0] noise [NE];

  // Model state: elapsed edges since accept drive everything.
  logic       m_busy = 1'b0, m_cmd_ready = 1'b0, m_vld = 1'b0, m_pulse = 1'b0;
  logic       m_stable = 1'b0, m_ns = 1'b0;
  logic [6:0] m_data = 7'h00, m_nd = 7'h00;
  logic [7:0] m_chal = 8'h00;
  int         m_t = 0;
  logic       mon_prev = 1'b0;

  puf_eval_ctrl dut (
    .i_clk           (i_clk),
    .i_rst           (i_rst),
    .i_cmd_valid     (i_cmd_valid),
    .o_cmd_ready     (o_cmd_ready),
    .i_cmd_challenge (i_cmd_challenge),
    .o_puf_challenge (o_puf_challenge),
    .o_puf_pulse     (o_puf_pulse),
    .i_puf_response  (i_puf_response),
    .o_rsp_valid     (o_rsp_valid),
    .i_rsp_ready     (i_rsp_ready),
    .o_rsp_data      (o_rsp_data),
    .o_rsp_stable    (o_rsp_stable),
    .o_busy          (o_busy)
  );

  initial forever #5 i_clk = ~i_clk;

  initial forever begin
    @(posedge i_clk);
    cyc = cyc + 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total = total + 1;
    if (act !== exp) begin
      bad = bad + 1;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [6:0] resp_of(input logic [7:0] c, input int k);
    logic [7:0] inv;
    int kk;
    inv = ~c;
    kk = (k < NE) ? k : NE - 1;
    return inv[6:0] ^ noise[kk];
  endfunction

  function automatic void expect_of(input logic [7:0] c, output logic [6:0] d, output logic s);
    logic [6:0] r;
    int ones;
    d = 7'h00;
    s = 1'b1;
    for (int b = 0; b < 7; b++) begin
      ones = 0;
      for (int k = 0; k < NE; k++) begin
        r = resp_of(c, k);
        ones = ones + int'(r[b]);
      end
      d[b] = (ones * 2 > NE);
      if (ones != 0 && ones != NE) s = 1'b0;
    end
  endfunction

  // Transaction model, advanced on every active edge.
  initial forever begin
    @(posedge i_clk or posedge i_rst);
    if (i_rst) begin
      m_busy = 1'b0; m_cmd_ready = 1'b0; m_vld = 1'b0; m_t = 0;
      m_data = 7'h00; m_stable = 1'b0; m_chal = 8'h00;
    end else if (!m_busy) begin
      if (i_cmd_valid && m_cmd_ready) begin
        m_busy = 1'b1; m_cmd_ready = 1'b0; m_t = 0; m_chal = i_cmd_challenge;
        expect_of(i_cmd_challenge, m_nd, m_ns);
      end else begin
        m_cmd_ready = 1'b1;
      end
    end else if (m_vld && i_rsp_ready) begin
      m_busy = 1'b0; m_vld = 1'b0; m_cmd_ready = 1'b1;
    end else begin
      m_t = m_t + 1;
      if (m_t == LAT) begin
        m_vld = 1'b1; m_data = m_nd; m_stable = m_ns;
      end
    end
    m_pulse = m_busy && (m_t < NE * PER) && ((m_t % PER) >= SET);
  end

  // Every-cycle comparison against the model.
  initial forever begin
    @(negedge i_clk);
    chk("cmp_cmd_ready", 32'(o_cmd_ready), 32'(m_cmd_ready));
    chk("cmp_busy", 32'(o_busy), 32'(m_busy));
    chk("cmp_pulse", 32'(o_puf_pulse), 32'(m_pulse));
    chk("cmp_rsp_valid", 32'(o_rsp_valid), 32'(m_vld));
    chk("cmp_challenge", 32'(o_puf_challenge), 32'(m_chal));
    chk("cmp_rsp_data", 32'(o_rsp_data), 32'(m_data));
    chk("cmp_rsp_stable", 32'(o_rsp_stable), 32'(m_stable));
  end

  // Behavioural PUF: resolves on pulse rise, drifts to garbage once the pulse falls.
  initial forever begin
    @(negedge i_clk);
    if (o_puf_pulse && !mon_prev) i_puf_response = resp_of(m_chal, m_t / PER);
    else if (!o_puf_pulse && mon_prev) i_puf_response = ~i_puf_response;
    mon_prev = o_puf_pulse;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic send(input logic [7:0] c, output int acc);
    @(posedge i_clk); #1;
    i_cmd_valid = 1'b1; i_cmd_challenge = c;
    @(posedge i_clk); #1;
    i_cmd_valid = 1'b0;
    acc = cyc;
  endtask

  task automatic wait_rsp(output logic [6:0] d, output logic s, output int at);
    logic got;
    got = 1'b0; d = 7'h00; s = 1'b0; at = -1;
    for (int i = 0; i < 80 && !got; i++) begin
      @(negedge i_clk);
      if (o_rsp_valid) begin
        got = 1'b1; d = o_rsp_data; s = o_rsp_stable; at = cyc;
      end
    end
    if (!got) begin
      total = total + 1; bad = bad + 1;
      $display("FAIL rsp_timeout: rsp_valid never rose, expected within 80 cycles");
    end
  endtask

  task automatic txn(input string tag, input logic [7:0] c, input logic [6:0] ed, input logic es);
    int acc, at;
    logic [6:0] d;
    logic s;
    send(c, acc);
    wait_rsp(d, s, at);
    chk({tag, "_data"}, 32'(d), 32'(ed));
    chk({tag, "_stable"}, 32'(s), 32'(es));
    chk({tag, "_latency"}, 32'(at - acc), 32'(LAT));
  endtask

  initial begin
    int acc, at1, at2, rises, lows, minlow, lat;
    logic prevp, got;
    logic [6:0] d;
    logic s;
    for (int k = 0; k < NE; k++) noise[k] = 7'h00;

    // Power-on reset.
    #1 i_rst = 1'b1;
    repeat (2) @(posedge i_clk);
    #1;
    chk("rst_cmd_ready", 32'(o_cmd_ready), 32'd0);
    chk("rst_busy", 32'(o_busy), 32'd0);
    chk("rst_pulse", 32'(o_puf_pulse), 32'd0);
    chk("rst_valid", 32'(o_rsp_valid), 32'd0);
    chk("rst_data", 32'(o_rsp_data), 32'd0);
    i_rst = 1'b0;
    @(negedge i_clk);
    chk("rst_rdy_first", 32'(o_cmd_ready), 32'd0);
    @(negedge i_clk);
    chk("rst_rdy_after", 32'(o_cmd_ready), 32'd1);

    // Deterministic run with pulse-shape accounting.
    send(8'hA5, acc);
    rises = 0; lows = 0; minlow = 1000; prevp = 1'b0; got = 1'b0; lat = -1;
    for (int i = 0; i < 60 && !got; i++) begin
      @(negedge i_clk);
      if (o_puf_pulse && !prevp) begin
        rises = rises + 1;
        if (lows < minlow) minlow = lows;
        lows = 0;
      end else if (!o_puf_pulse) begin
        lows = lows + 1;
      end
      prevp = o_puf_pulse;
      if (o_rsp_valid) begin
        got = 1'b1; lat = cyc - acc; d = o_rsp_data; s = o_rsp_stable;
      end
    end
    chk("det_got_valid", 32'(got), 32'd1);
    chk("det_latency", 32'(lat), 32'd36);
    chk("det_data", 32'(d), 32'h5A);
    chk("det_stable", 32'(s), 32'd1);
    chk("det_rises", 32'(rises), 32'd5);
    chk("det_min_low", 32'(minlow), 32'd4);

    // Noisy bit 0 with a challenge whose clean response is all zeros.
    noise[0] = 7'h01; noise[1] = 7'h00; noise[2] = 7'h01; noise[3] = 7'h01; noise[4] = 7'h00;
    txn("noisy_a", 8'h7F, 7'h01, 1'b0);
    noise[0] = 7'h00; noise[1] = 7'h00; noise[2] = 7'h01; noise[3] = 7'h00; noise[4] = 7'h00;
    txn("noisy_b", 8'h7F, 7'h00, 1'b0);
    for (int k = 0; k < NE; k++) noise[k] = 7'h00;

    // Reset during FIRE.
    send(8'h5A, acc);
    repeat (5) @(negedge i_clk);
    chk("mid_fire_pulse", 32'(o_puf_pulse), 32'd1);
    #2 i_rst = 1'b1;
    #1;
    chk("abort_pulse", 32'(o_puf_pulse), 32'd0);
    chk("abort_busy", 32'(o_busy), 32'd0);
    chk("abort_valid", 32'(o_rsp_valid), 32'd0);
    chk("abort_challenge", 32'(o_puf_challenge), 32'd0);
    repeat (2) @(posedge i_clk);
    #1 i_rst = 1'b0;
    @(negedge i_clk);
    chk("abort_rdy_first", 32'(o_cmd_ready), 32'd0);
    @(negedge i_clk);
    chk("abort_rdy_after", 32'(o_cmd_ready), 32'd1);

    // Back-pressure with a competing command.
    i_rsp_ready = 1'b0;
    send(8'h12, acc);
    wait_rsp(d, s, at1);
    chk("bp_latency", 32'(at1 - acc), 32'(LAT));
    chk("bp_data", 32'(d), 32'h6D);
    for (int i = 0; i < 10; i++) begin
      @(posedge i_clk); #1;
      i_cmd_valid = 1'b1; i_cmd_challenge = 8'h3C;
      @(negedge i_clk);
      chk("bp_hold_valid", 32'(o_rsp_valid), 32'd1);
      chk("bp_hold_data", 32'(o_rsp_data), 32'h6D);
      chk("bp_hold_stable", 32'(o_rsp_stable), 32'd1);
    end
    chk("bp_not_accepted", 32'(o_puf_challenge), 32'h12);
    @(posedge i_clk); #1;
    i_rsp_ready = 1'b1;
    @(posedge i_clk);
    @(negedge i_clk);
    chk("bp_idle_ready", 32'(o_cmd_ready), 32'd1);
    chk("bp_idle_chal", 32'(o_puf_challenge), 32'h12);
    @(posedge i_clk); #1;
    acc = cyc;
    i_cmd_valid = 1'b0;
    chk("bp_accepted", 32'(o_puf_challenge), 32'h3C);
    chk("bp_busy", 32'(o_busy), 32'd1);
    wait_rsp(d, s, at1);
    chk("bp2_latency", 32'(at1 - acc), 32'(LAT));
    chk("bp2_data", 32'(d), 32'h43);

    // Back-to-back with cmd_valid held high.
    @(posedge i_clk); #1;
    i_cmd_valid = 1'b1; i_cmd_challenge = 8'h00;
    @(posedge i_clk); #1;
    acc = cyc;
    i_cmd_challenge = 8'hFF;
    wait_rsp(d, s, at1);
    chk("b2b_first_lat", 32'(at1 - acc), 32'(LAT));
    chk("b2b_first_data", 32'(d), 32'h7F);
    chk("b2b_first_stable", 32'(s), 32'd1);
    wait_rsp(d, s, at2);
    i_cmd_valid = 1'b0;
    chk("b2b_gap", 32'(at2 - at1), 32'd38);
    chk("b2b_second_data", 32'(d), 32'h00);
    chk("b2b_second_stable", 32'(s), 32'd1);
    chk("b2b_chal", 32'(o_puf_challenge), 32'hFF);

    repeat (4) @(posedge i_clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
